// File: rtl/history_update_ctrl_pkg.sv
// Shared types and sizing for the branch-history update controller.
// The optional performance counters are enabled with HIST_CTRL_PERF_EN.
package history_update_ctrl_pkg;

    localparam int GLOBAL_HIST_LEN          = 16;
    localparam int MAX_ROLLBACK_CYCLES_INCL = 4;
    localparam int HIST_CNT_W               = $clog2(MAX_ROLLBACK_CYCLES_INCL + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_ROLLBACK,
        ST_REPAIR
    } hist_ctrl_state_e;

    typedef struct packed {
        logic                  enable;
        logic                  is_rollback;
        logic [HIST_CNT_W-1:0] rollback_cycles;
        logic                  taken;
    } hist_update_t;

endpackage

// File: rtl/history_update_ctrl_if.sv
// Fetch/execute handshakes plus the history update bus of history_update_ctrl.
// The slave modport is the controller; the master modport is the surrounding pipeline.
interface history_update_ctrl_if #(
    parameter int CNT_W = history_update_ctrl_pkg::HIST_CNT_W
);
    logic             spec_valid;
    logic             spec_taken;
    logic             spec_ready;
    logic             res_valid;
    logic             res_taken;
    logic             res_ready;
    logic             upd_enable;
    logic             upd_is_rollback;
    logic [CNT_W-1:0] upd_rollback_cycles;
    logic             upd_taken;
    logic             hist_stall;

    modport master (
        output spec_valid, spec_taken, res_valid, res_taken,
        input  spec_ready, res_ready, upd_enable, upd_is_rollback,
               upd_rollback_cycles, upd_taken, hist_stall
    );

    modport slave (
        input  spec_valid, spec_taken, res_valid, res_taken,
        output spec_ready, res_ready, upd_enable, upd_is_rollback,
               upd_rollback_cycles, upd_taken, hist_stall
    );

endinterface

// File: rtl/history_update_ctrl_spec_bit_fifo.sv
// One-bit-wide FIFO holding the predicted directions of in-flight branches.
// Flush wins over push/pop so a mispredict discards everything in one cycle.
module spec_bit_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             push_bit_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W-1:0] wrPtr_q;
    logic [CNT_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q   <= '0;
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wrPtr_q] <= push_bit_i;
                wrPtr_q        <= nextPtr(wrPtr_q);
            end
            if (pop_i) begin
                rdPtr_q <= nextPtr(rdPtr_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/history_update_ctrl.sv
// Sequences speculative shifts, rollbacks and repairs into the branch-history blocks.
// Define HIST_CTRL_PERF_EN to add saturating resolve/mispredict/full-cycle counters.
module history_update_ctrl
    import history_update_ctrl_pkg::*;
#(
    parameter int DEPTH = MAX_ROLLBACK_CYCLES_INCL,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ext_stall_i,
    history_update_ctrl_if.slave bus,
    output logic [CNT_W-1:0]     inflight_o
`ifdef HIST_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_resolves_o,
    output logic [31:0]          perf_mispredicts_o,
    output logic [31:0]          perf_full_cycles_o
`endif
);

    hist_ctrl_state_e state_q;
    hist_update_t     upd_q;
    logic             histStall_q;
    logic             repairTaken_q;

    logic             fifoHead;
    logic [CNT_W-1:0] fifoCount;
    logic             runActive;
    logic             resFire;
    logic             mispredict;
    logic             pushFire;
    logic             popFire;

    assign runActive  = (state_q == ST_RUN) && !ext_stall_i;
    assign bus.res_ready = runActive && (fifoCount != '0);
    assign resFire    = bus.res_valid && bus.res_ready;
    assign mispredict = resFire && (bus.res_taken != fifoHead);
    assign bus.spec_ready = runActive && (fifoCount < CNT_W'(DEPTH)) && !mispredict;
    assign pushFire   = bus.spec_valid && bus.spec_ready;
    assign popFire    = resFire && !mispredict;

    spec_bit_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (pushFire),
        .push_bit_i (bus.spec_taken),
        .pop_i      (popFire),
        .flush_i    (mispredict),
        .head_o     (fifoHead),
        .count_o    (fifoCount)
    );

    // Outputs are registered one cycle ahead: the bus value seen while in a
    // state is the one loaded on entry. ext_stall freezes everything so a
    // pending shift or rollback is presented again once the stall clears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            upd_q         <= '0;
            histStall_q   <= 1'b1;
            repairTaken_q <= 1'b0;
        end else if (!ext_stall_i) begin
            case (state_q)
                ST_RUN: begin
                    if (mispredict) begin
                        upd_q         <= '{enable: 1'b1, is_rollback: 1'b1,
                                           rollback_cycles: HIST_CNT_W'(fifoCount),
                                           taken: upd_q.taken};
                        histStall_q   <= 1'b0;
                        repairTaken_q <= bus.res_taken;
                        state_q       <= ST_ROLLBACK;
                    end else if (pushFire) begin
                        upd_q       <= '{enable: 1'b0, is_rollback: 1'b0,
                                         rollback_cycles: '0, taken: bus.spec_taken};
                        histStall_q <= 1'b0;
                    end else begin
                        upd_q       <= '{enable: 1'b0, is_rollback: 1'b0,
                                         rollback_cycles: '0, taken: upd_q.taken};
                        histStall_q <= 1'b1;
                    end
                end
                ST_ROLLBACK: begin
                    upd_q       <= '{enable: 1'b0, is_rollback: 1'b0,
                                     rollback_cycles: '0, taken: repairTaken_q};
                    histStall_q <= 1'b0;
                    state_q     <= ST_REPAIR;
                end
                default: begin
                    upd_q       <= '{enable: 1'b0, is_rollback: 1'b0,
                                     rollback_cycles: '0, taken: upd_q.taken};
                    histStall_q <= 1'b1;
                    state_q     <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.upd_enable          = upd_q.enable;
    assign bus.upd_is_rollback     = upd_q.is_rollback;
    assign bus.upd_rollback_cycles = CNT_W'(upd_q.rollback_cycles);
    assign bus.upd_taken           = upd_q.taken;
    assign bus.hist_stall          = histStall_q || ext_stall_i;
    assign inflight_o              = fifoCount;

`ifdef HIST_CTRL_PERF_EN
    logic [31:0] perfResolves_q;
    logic [31:0] perfMispredicts_q;
    logic [31:0] perfFullCycles_q;

    // Saturate rather than wrap so a long run never reports a small count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perfResolves_q    <= '0;
            perfMispredicts_q <= '0;
            perfFullCycles_q  <= '0;
        end else if (!ext_stall_i) begin
            if (resFire && (perfResolves_q != '1)) begin
                perfResolves_q <= perfResolves_q + 32'd1;
            end
            if (mispredict && (perfMispredicts_q != '1)) begin
                perfMispredicts_q <= perfMispredicts_q + 32'd1;
            end
            if ((fifoCount == CNT_W'(DEPTH)) && (perfFullCycles_q != '1)) begin
                perfFullCycles_q <= perfFullCycles_q + 32'd1;
            end
        end
    end

    assign perf_resolves_o    = perfResolves_q;
    assign perf_mispredicts_o = perfMispredicts_q;
    assign perf_full_cycles_o = perfFullCycles_q;
`endif

endmodule

// File: tb/tb_history_update_ctrl.sv
// Self-checking bench for history_update_ctrl: directed scenarios then random traffic,
// all compared against a transaction-level model (queue of predictions + expected bus events).
module tb_history_update_ctrl;
    import history_update_ctrl_pkg::*;

    localparam int DEPTH = MAX_ROLLBACK_CYCLES_INCL;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct {
        bit stall;
        bit en;
        bit rb;
        int cnt;
        bit taken;
    } busEvent_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             extStall;
    logic [CNT_W-1:0] inflight;

    int checks = 0;
    int errors = 0;

    bit        modelQ[$];
    busEvent_t curEv;
    busEvent_t pendEv[$];
    int        modelResolves;
    int        modelMispredicts;
    int        modelFullCycles;

    history_update_ctrl_if #(.CNT_W(CNT_W)) bus ();

`ifdef HIST_CTRL_PERF_EN
    logic [31:0] perfResolves;
    logic [31:0] perfMispredicts;
    logic [31:0] perfFullCycles;
`endif

    history_update_ctrl #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .ext_stall_i (extStall),
        .bus         (bus),
        .inflight_o  (inflight)
`ifdef HIST_CTRL_PERF_EN
        ,
        .perf_resolves_o    (perfResolves),
        .perf_mispredicts_o (perfMispredicts),
        .perf_full_cycles_o (perfFullCycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic busEvent_t idleEv();
        busEvent_t e = '{stall: 1'b1, en: 1'b0, rb: 1'b0, cnt: 0, taken: 1'b0};
        return e;
    endfunction

    function automatic busEvent_t shiftEv(input bit t);
        busEvent_t e = '{stall: 1'b0, en: 1'b0, rb: 1'b0, cnt: 0, taken: t};
        return e;
    endfunction

    function automatic busEvent_t rollbackEv(input int n);
        busEvent_t e = '{stall: 1'b0, en: 1'b1, rb: 1'b1, cnt: n, taken: 1'b0};
        return e;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        modelQ.delete();
        pendEv.delete();
        curEv            = idleEv();
        modelResolves    = 0;
        modelMispredicts = 0;
        modelFullCycles  = 0;
    endtask

    // One clock of stimulus: drive on the falling edge, check shortly after,
    // then advance the model to what the next cycle should show.
    task automatic applyStimulus(input bit sv, input bit st, input bit rv, input bit rt, input bit xs);
        bit running;
        bit expResReady;
        bit expSpecReady;
        bit mis;
        @(negedge clk);
        bus.spec_valid = sv;
        bus.spec_taken = st;
        bus.res_valid  = rv;
        bus.res_taken  = rt;
        extStall       = xs;
        #1;
        running     = (pendEv.size() == 0) && !xs;
        expResReady = running && (modelQ.size() != 0);
        mis         = 1'b0;
        if (expResReady) mis = rv && (rt != modelQ[0]);
        expSpecReady = running && (modelQ.size() < DEPTH) && !mis;

        checkOutput("spec_ready", int'(bus.spec_ready), int'(expSpecReady));
        checkOutput("res_ready", int'(bus.res_ready), int'(expResReady));
        checkOutput("inflight", int'(inflight), modelQ.size());
        checkOutput("hist_stall", int'(bus.hist_stall), int'(curEv.stall || xs));
        checkOutput("upd_enable", int'(bus.upd_enable), int'(curEv.en));
        checkOutput("upd_is_rollback", int'(bus.upd_is_rollback), int'(curEv.rb));
        if (curEv.en) checkOutput("upd_rollback_cycles", int'(bus.upd_rollback_cycles), curEv.cnt);
        if (!curEv.stall && !curEv.en) checkOutput("upd_taken", int'(bus.upd_taken), int'(curEv.taken));

        if (!xs) begin
            if (modelQ.size() == DEPTH) modelFullCycles++;
            if (pendEv.size() != 0) begin
                curEv = pendEv.pop_front();
            end else if (mis) begin
                modelResolves++;
                modelMispredicts++;
                curEv = rollbackEv(modelQ.size());
                pendEv.push_back(shiftEv(rt));
                pendEv.push_back(idleEv());
                modelQ.delete();
            end else begin
                if (rv && expResReady) begin
                    void'(modelQ.pop_front());
                    modelResolves++;
                end
                if (sv && expSpecReady) begin
                    modelQ.push_back(st);
                    curEv = shiftEv(st);
                end else begin
                    curEv = idleEv();
                end
            end
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_hist_stall"}, int'(bus.hist_stall), 1);
        checkOutput({tag, "_upd_enable"}, int'(bus.upd_enable), 0);
        checkOutput({tag, "_upd_is_rollback"}, int'(bus.upd_is_rollback), 0);
        checkOutput({tag, "_inflight"}, int'(inflight), 0);
        checkOutput({tag, "_spec_ready"}, int'(bus.spec_ready), 1);
        checkOutput({tag, "_res_ready"}, int'(bus.res_ready), 0);
    endtask

    initial begin
        bit head;
        reset          = 1'b0;
        extStall       = 1'b0;
        bus.spec_valid = 1'b0;
        bus.spec_taken = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;
        resetModel();
        repeat (2) @(negedge clk);
        #1;
        checkResetOutputs("reset");
        #2;
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);

        // Three pushes T,N,T, then an idle cycle to see the last shift.
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Fill to DEPTH, try one more, then free a slot with a correct resolve.
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(1, 1, 0, 0, 0);

        // Leave T at the head with three in flight, then mispredict with a push.
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Push plus correct resolve together at two in flight.
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Stall in the middle of a rollback, then reset during the next one.
        applyStimulus(0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        @(negedge clk);
        bus.spec_valid = 1'b0;
        bus.res_valid  = 1'b0;
        #1;
        checkOutput("pre_reset_upd_enable", int'(bus.upd_enable), int'(curEv.en));
        reset = 1'b0;
        #1;
        checkResetOutputs("midreset");
        resetModel();
        #2;
        reset = 1'b1;
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Random traffic: resolves mostly agree with the model head.
        for (int i = 0; i < 800; i++) begin
            head = (modelQ.size() != 0) ? modelQ[0] : 1'b0;
            if ($urandom_range(0, 7) == 0) head = !head;
            applyStimulus(bit'($urandom_range(0, 9) < 6), bit'($urandom_range(0, 1)),
                          bit'($urandom_range(0, 9) < 4), head,
                          bit'($urandom_range(0, 9) == 0));
        end
        applyStimulus(0, 0, 0, 0, 0);

`ifdef HIST_CTRL_PERF_EN
        #1;
        checkOutput("perf_resolves", int'(perfResolves), modelResolves);
        checkOutput("perf_mispredicts", int'(perfMispredicts), modelMispredicts);
        checkOutput("perf_full_cycles", int'(perfFullCycles), modelFullCycles);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog observed timeout expected completion at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
